// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares one single-ported data memory between two requesters. Port 0 is the
// CPU load/store path and port 1 is the debug/loader port. Every access runs
// IDLE -> ISSUE -> DONE. The winner is picked in IDLE and its request fields
// are latched there. The memory operation happens in ISSUE. DONE pulses the
// winner's done line and captures the registered read data.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration on a collision
//                       undefined -> fixed priority, port 0 wins a collision
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   req*_i / we*_i         per-port request (held until done) and write select
//   addr*_i / wdata*_i     per-port word address and write data
//   done*_o / err*_o       one-cycle completion pulse and out-of-range flag
//   rdata_o                data of the last completed read
//   gnt_o                  port that owns the access in flight
//   mem_write / mem_read   memory enables (only ever high in ISSUE)
//   mem_addr / mem_wdata   memory address and write data
//   mem_rdata              memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              gnt_o,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              err_pend;
  logic              gnt_q;
  logic [DATA_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              win;
  logic              in_range;
  logic              issue_ok;

  assign any_req  = req0_i | req1_i;
  // Only the low ADDR_BITS of the word address may be set.
  assign in_range = ((lat_addr >> ADDR_BITS) == '0);
  assign issue_ok = (state == S_ISSUE) && in_range;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers the last granted port; starts at 1 so port 0 wins the first
  // collision after reset. It moves on every grant, not only on collisions.
  logic rr_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if ((state == S_IDLE) && any_req) begin
      rr_last <= win;
    end
  end
`endif

  // Winner select: a lone requester always wins; a collision goes to the
  // port not granted last (round-robin) or to port 0 (fixed priority).
  always_comb begin
    win = 1'b0;
    if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~rr_last;
`else
      win = 1'b0;
`endif
    end else if (req1_i) begin
      win = 1'b1;
    end
  end

  // Access sequencer. Request fields are latched at grant and frozen until
  // DONE, so requester inputs are ignored once an access is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_pend  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_q     <= win;
            lat_we    <= win ? we1_i    : we0_i;
            lat_addr  <= win ? addr1_i  : addr0_i;
            lat_wdata <= win ? wdata1_i : wdata0_i;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          err_pend <= ~in_range;
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory address/data hold their last driven values outside ISSUE, so
  // they are refreshed only by an access that really reaches the memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (issue_ok) begin
      addr_hold  <= lat_addr;
      wdata_hold <= lat_wdata;
    end
  end

  // Read data capture in DONE: memory data for an in-range read, zero for a
  // rejected read; writes leave the previous read result in place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if ((state == S_DONE) && !lat_we) begin
      rdata_q <= err_pend ? '0 : mem_rdata;
    end
  end

  // Enables and handshake outputs decode straight from the state register,
  // so an async reset drops them at once and no write lands on the next edge.
  assign mem_write = issue_ok &  lat_we;
  assign mem_read  = issue_ok & ~lat_we;
  assign mem_addr  = issue_ok ? lat_addr  : addr_hold;
  assign mem_wdata = issue_ok ? lat_wdata : wdata_hold;

  assign done0_o = (state == S_DONE) & ~gnt_q;
  assign done1_o = (state == S_DONE) &  gnt_q;
  assign err0_o  = done0_o & err_pend;
  assign err1_o  = done1_o & err_pend;
  assign gnt_o   = gnt_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Bench for data_memory_arbiter with a behavioural registered memory. Each
// access pushes its expected outcome (port, error flag, read data) onto a
// queue when driven; a monitor pops the queue on every done pulse and checks
// rdata_o one cycle later. Collision order follows ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0_o, done1_o, err0_o, err1_o, gnt_o;
  logic [31:0] rdata_o;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] envMem [0:31];
  logic [31:0] refMem [0:31];
  exp_t        expQ[$];
  int          compareCount = 0;
  int          mismatchCount = 0;
  int          cyc = 0;
  int          doneCount = 0;
  int          enCount = 0;
  logic        rdPending = 1'b0;
  logic [31:0] rdExpect = 32'h0;
  logic        lastGnt = 1'b1;

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .done0_o(done0_o), .done1_o(done1_o), .err0_o(err0_o), .err1_o(err1_o),
    .rdata_o(rdata_o), .gnt_o(gnt_o),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Registered single-port memory seen by the arbiter.
  always @(posedge clock) begin
    cyc++;
    if (mem_write) envMem[mem_addr[4:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= envMem[mem_addr[4:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compareCount++;
    if (got !== expv) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
    end
  endtask

  // Builds the expected outcome of one access and updates the reference memory.
  function automatic exp_t makeExp(input logic port, input logic we, input logic [31:0] addr,
                                   input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.err  = (addr >= 32);
    e.rd   = ~we;
    e.data = 32'h0;
    if (!e.err) begin
      if (we) refMem[addr[4:0]] = data;
      else    e.data = refMem[addr[4:0]];
    end
    return e;
  endfunction

  // Scoreboard monitor: pop on done, check read data the following cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (mem_write || mem_read) enCount++;
    if (rdPending) begin
      checkOutput("rdata", rdata_o, rdExpect);
      rdPending = 1'b0;
    end
    if (done0_o || done1_o) begin
      doneCount++;
      checkOutput("single_done", 32'(done0_o & done1_o), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("done_expected", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("done_port", 32'(done1_o), 32'(e.port));
        checkOutput("done_err", 32'(err0_o | err1_o), 32'(e.err));
        if (e.rd) begin
          rdPending = 1'b1;
          rdExpect  = e.data;
        end
      end
    end
  end

  // Drives one access on either port, or a collision when both are enabled,
  // and releases each request the cycle after its done pulse.
  task automatic applyStimulus(input logic use0, input logic use1,
                               input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic win;
    logic p0 = use0;
    logic p1 = use1;
    logic s0, s1;
    int   t0 = 0;
    int   t1 = 0;
    @(posedge clock); #1;
    if (use0 && use1) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~lastGnt;
`else
      win = 1'b0;
`endif
      if (win) begin
        expQ.push_back(makeExp(1'b1, w1, a1, d1));
        expQ.push_back(makeExp(1'b0, w0, a0, d0));
      end else begin
        expQ.push_back(makeExp(1'b0, w0, a0, d0));
        expQ.push_back(makeExp(1'b1, w1, a1, d1));
      end
      lastGnt = ~win;
    end else begin
      win = use1;
      if (use0) expQ.push_back(makeExp(1'b0, w0, a0, d0));
      if (use1) expQ.push_back(makeExp(1'b1, w1, a1, d1));
      lastGnt = use1;
    end
    if (use0) begin req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0; end
    if (use1) begin req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1; end
    for (int c = 0; c < 30 && (p0 || p1); c++) begin
      @(negedge clock);
      s0 = done0_o;
      s1 = done1_o;
      if (s0 || s1) begin
        @(posedge clock); #1;
        if (s0) begin req0 = 1'b0; p0 = 1'b0; t0 = cyc; end
        if (s1) begin req1 = 1'b0; p1 = 1'b0; t1 = cyc; end
      end
    end
    checkOutput("access_timeout", 32'(p0 | p1), 32'd0);
    if (use0 && use1)
      checkOutput("collide_gap", 32'(win ? (t0 - t1) : (t1 - t0)), 32'd3);
  endtask

  int enSnap, doneSnap, k;
  int tDone [0:3];

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    for (int i = 0; i < 32; i++) begin
      envMem[i] = i * 32'h01010101;
      refMem[i] = i * 32'h01010101;
    end
    repeat (3) @(posedge clock); #1;
    checkOutput("rst_done", 32'({done0_o, done1_o, err0_o, err1_o}), 32'd0);
    checkOutput("rst_enables", 32'({mem_write, mem_read}), 32'd0);
    checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    reset = 1'b0;
    lastGnt = 1'b1;

    // Cycle-exact write: request at edge N, write in N+1, done in N+2.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'hDEADBEEF;
    expQ.push_back(makeExp(1'b0, 1'b1, 32'd3, 32'hDEADBEEF));
    @(negedge clock);
    checkOutput("t_idle_we", 32'(mem_write), 32'd0);
    @(negedge clock);
    checkOutput("t_issue_we", 32'(mem_write), 32'd1);
    checkOutput("t_issue_addr", mem_addr, 32'd3);
    checkOutput("t_issue_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clock);
    checkOutput("t_done0", 32'(done0_o), 32'd1);
    checkOutput("t_done_we", 32'(mem_write), 32'd0);
    @(posedge clock); #1;
    req0 = 1'b0;
    lastGnt = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd6, 32'h66, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    checkOutput("rdata_hold_on_write", rdata_o, 32'hDEADBEEF);

    // Out-of-range read must never touch the memory and returns zero.
    enSnap = enCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'd32, 32'h0);
    checkOutput("oor_no_mem", 32'(enCount - enSnap), 32'd0);

    // Collisions: the second one follows a lone port-0 grant.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 32'd2, 32'h22223333);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 32'd4, 32'h44445555);

    // Inputs changed after grant must not reach the memory.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hA5A5A5A5;
    expQ.push_back(makeExp(1'b0, 1'b1, 32'd7, 32'hA5A5A5A5));
    lastGnt = 1'b0;
    @(posedge clock); #1;
    addr0 = 32'd9; wdata0 = 32'h0BADF00D;
    @(negedge clock);
    checkOutput("frz_we", 32'(mem_write), 32'd1);
    checkOutput("frz_addr", mem_addr, 32'd7);
    checkOutput("frz_wdata", mem_wdata, 32'hA5A5A5A5);
    @(negedge clock);
    checkOutput("frz_done", 32'(done0_o), 32'd1);
    @(posedge clock); #1;
    req0 = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'd9, 32'h0);

    // Reset during ISSUE of a write aborts it with no done.
    doneSnap = doneCount;
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'h1234;
    @(posedge clock); #1;
    checkOutput("rst_pre_we", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_we", 32'(mem_write), 32'd0);
    req0 = 1'b0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    lastGnt = 1'b1;
    checkOutput("rst_no_done", 32'(doneCount - doneSnap), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'd5, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd8, 32'h88, 1'b0, 32'd4, 32'h0);

    // Back-to-back: req0 held across four accesses, fields renewed per done.
    doneSnap = doneCount;
    expQ.push_back(makeExp(1'b0, 1'b1, 32'd10, 32'hB0B0B0B0));
    expQ.push_back(makeExp(1'b0, 1'b1, 32'd11, 32'hB1B1B1B1));
    expQ.push_back(makeExp(1'b0, 1'b0, 32'd10, 32'h0));
    expQ.push_back(makeExp(1'b0, 1'b0, 32'd11, 32'h0));
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd10; wdata0 = 32'hB0B0B0B0;
    k = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clock);
      if (done0_o) begin
        tDone[k] = cyc;
        k++;
        @(posedge clock); #1;
        case (k)
          1: begin we0 = 1'b1; addr0 = 32'd11; wdata0 = 32'hB1B1B1B1; end
          2: begin we0 = 1'b0; addr0 = 32'd10; end
          3: begin we0 = 1'b0; addr0 = 32'd11; end
          default: req0 = 1'b0;
        endcase
      end
    end
    checkOutput("b2b_count", 32'(k), 32'd4);
    for (int i = 1; i < 4; i++)
      checkOutput("b2b_gap", 32'(tDone[i] - tDone[i-1]), 32'd3);
    enSnap = enCount;
    repeat (8) @(negedge clock);
    checkOutput("b2b_total_done", 32'(doneCount - doneSnap), 32'd4);
    checkOutput("b2b_no_extra", 32'(enCount - enSnap), 32'd0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] arbitration model last grant %0d", lastGnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
